// File: rtl/delay_line_sync.sv
// delay_line_sync
//   Parametrised synchronous register delay line. A WIDTH-bit sample and its
//   valid bit shift through DEPTH posedge register stages. The line supports
//   stall (en_i low), flush (valid bits and fill count cleared, data kept), a
//   runtime-selectable tap, and a running count of valid stages.
//
//   Valid semantics: there is no backpressure. valid_i marks d_i as a real
//   sample on every enabled edge. Data shifts regardless of valid_i, so bubbles
//   travel with their valid bit low. Consumers qualify q_o with q_valid_o and
//   tap_o with tap_valid_o.
//
// Ports
//   clk_i        clock, all state changes on posedge
//   rst_i        synchronous active-high reset (wins over everything)
//   en_i         shift enable, 0 holds all state
//   flush_i      clear every valid bit and the fill count, keep data
//   valid_i      d_i carries a real sample
//   d_i          sample into stage 0
//   tap_sel_i    stage index driven on tap_o (values >= DEPTH pick DEPTH-1)
//   q_o          data of stage DEPTH-1
//   q_valid_o    valid bit of stage DEPTH-1
//   tap_o        data of the selected stage
//   tap_valid_o  valid bit of the selected stage
//   fill_o       number of stages holding a valid sample
//   primed_o     fill_o == DEPTH
module delay_line_sync #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              FW        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [TW-1:0]    tap_sel_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic [WIDTH-1:0] tap_o,
  output logic             tap_valid_o,
  output logic [FW-1:0]    fill_o,
  output logic             primed_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [FW-1:0]    fill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else if (flush_i) begin
      // Data registers intentionally keep their contents; only validity is lost.
      vld_q  <= '0;
      fill_q <= '0;
    end else if (en_i) begin
      data_q[0] <= d_i;
      vld_q[0]  <= valid_i;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k] <= data_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
      // Entry and exit in the same edge cancel, so fill stays in 0..DEPTH.
      fill_q <= fill_q + FW'(valid_i) - FW'(vld_q[DEPTH-1]);
    end
  end

  // Tap mux defaults to the last stage, which also covers out-of-range
  // selects and makes DEPTH=1 collapse to tap_o = q_o.
  always_comb begin
    tap_o       = data_q[DEPTH-1];
    tap_valid_o = vld_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(tap_sel_i) == k) begin
        tap_o       = data_q[k];
        tap_valid_o = vld_q[k];
      end
    end
  end

  assign q_o       = data_q[DEPTH-1];
  assign q_valid_o = vld_q[DEPTH-1];
  assign fill_o    = fill_q;
  assign primed_o  = (fill_q == FW'(DEPTH));

endmodule

// File: tb/tb_delay_line_sync.sv
// tb_delay_line_sync
//   Directed bench for delay_line_sync (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5).
//   The reference model is a history queue: hist[k] is the sample accepted k
//   enabled edges ago, so stage k of the line must equal hist[k].
module tb_delay_line_sync;

  localparam int             WIDTH = 8;
  localparam int             DEPTH = 4;
  localparam logic [7:0]     RV    = 8'hA5;

  // ---------------- clock / reset signals ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] d = '0;
  logic [1:0] tap_sel = '0;
  logic [7:0] q, tap;
  logic       q_valid, tap_valid, primed;
  logic [2:0] fill;

  always #5 clk = ~clk;

  delay_line_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .valid_i(valid),
    .d_i(d), .tap_sel_i(tap_sel), .q_o(q), .q_valid_o(q_valid), .tap_o(tap),
    .tap_valid_o(tap_valid), .fill_o(fill), .primed_o(primed)
  );

  // ---------------- scoreboard / model ----------------
  typedef struct packed { logic v; logic [7:0] d; } ent_t;
  ent_t hist[$];
  bit   model_on = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic f, input logic e,
                            input logic v, input logic [7:0] dd);
    if (r) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back('{v: 1'b0, d: RV});
      model_on = 1'b1;
    end else if (!model_on) begin
      // nothing known before the first reset
    end else if (f) begin
      for (int i = 0; i < DEPTH; i++) hist[i].v = 1'b0;
    end else if (e) begin
      hist.push_front('{v: v, d: dd});
      void'(hist.pop_back());
    end
  endtask

  function automatic int exp_fill();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(hist[i].v);
    return c;
  endfunction

  // Compare process: every cycle, 2 time units after the edge.
  always @(posedge clk) begin
    int idx;
    #2;
    if (model_on) begin
      idx = (int'(tap_sel) > DEPTH - 1) ? DEPTH - 1 : int'(tap_sel);
      chk("cyc_q",        32'(q),         32'(hist[DEPTH-1].d));
      chk("cyc_q_valid",  32'(q_valid),   32'(hist[DEPTH-1].v));
      chk("cyc_tap",      32'(tap),       32'(hist[idx].d));
      chk("cyc_tap_valid",32'(tap_valid), 32'(hist[idx].v));
      chk("cyc_fill",     32'(fill),      32'(exp_fill()));
      chk("cyc_primed",   32'(primed),    32'(exp_fill() == DEPTH));
    end
  end

  // ---------------- driver tasks ----------------
  // Drive inputs, take one edge, update the model, return 4 units later.
  task automatic step(input logic r, input logic f, input logic e,
                      input logic v, input logic [7:0] dd);
    rst = r; flush = f; en = e; valid = v; d = dd;
    @(posedge clk);
    model_edge(r, f, e, v, dd);
    #4;
  endtask

  task automatic push(input logic v, input logic [7:0] dd);
    step(1'b0, 1'b0, 1'b1, v, dd);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #2;
    // Reset with junk on the inputs
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    chk("rst_q",      32'(q),       32'hA5);
    chk("rst_tap",    32'(tap),     32'hA5);
    chk("rst_qv",     32'(q_valid), 32'd0);
    chk("rst_fill",   32'(fill),    32'd0);
    chk("rst_primed", 32'(primed),  32'd0);

    // Streaming
    push(1'b1, 8'h01);
    chk("s1_fill", 32'(fill), 32'd1);
    push(1'b1, 8'h02);
    push(1'b1, 8'h03);
    chk("s3_qv", 32'(q_valid), 32'd0);
    push(1'b1, 8'h04);
    chk("s4_q",      32'(q),       32'h01);
    chk("s4_qv",     32'(q_valid), 32'd1);
    chk("s4_fill",   32'(fill),    32'd4);
    chk("s4_primed", 32'(primed),  32'd1);
    push(1'b1, 8'h05);
    chk("s5_q",    32'(q),    32'h02);
    chk("s5_fill", 32'(fill), 32'd4);

    // Stall for 3 cycles with toggling data
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, i[0], (i[0] ? 8'hFF : 8'h00));
      chk("stall_q",    32'(q),    32'h02);
      chk("stall_fill", 32'(fill), 32'd4);
      chk("stall_tap",  32'(tap),  32'h05);
    end
    push(1'b1, 8'h06);
    chk("resume_q", 32'(q), 32'h03);

    // Bubble travels through
    push(1'b0, 8'hEE);
    chk("bub_in_fill", 32'(fill), 32'd3);
    push(1'b1, 8'h07);
    push(1'b1, 8'h08);
    push(1'b1, 8'h09);
    chk("bub_out_qv",   32'(q_valid), 32'd0);
    chk("bub_out_fill", 32'(fill),    32'd3);
    push(1'b1, 8'h0A);
    chk("bub_after_q",    32'(q),    32'h07);
    chk("bub_after_fill", 32'(fill), 32'd4);

    // Taps
    push(1'b1, 8'h10);
    push(1'b1, 8'h20);
    push(1'b1, 8'h30);
    push(1'b1, 8'h40);
    chk("tap0", 32'(tap), 32'h40);
    tap_sel = 2'd2; #1;
    chk("tap2", 32'(tap), 32'h20);
    tap_sel = 2'd3; #1;
    chk("tap3", 32'(tap), 32'h10);
    tap_sel = 2'd1; #1;
    chk("tap1", 32'(tap), 32'h30);
    tap_sel = 2'd0; #1;

    // Flush with en high: 77 must not be captured
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    chk("fl_fill",   32'(fill),      32'd0);
    chk("fl_qv",     32'(q_valid),   32'd0);
    chk("fl_primed", 32'(primed),    32'd0);
    chk("fl_q",      32'(q),         32'h10);
    chk("fl_tap",    32'(tap),       32'h40);
    chk("fl_tapv",   32'(tap_valid), 32'd0);

    // Refill partially, then flush during a stall
    push(1'b1, 8'h51);
    push(1'b1, 8'h52);
    chk("rf_fill", 32'(fill), 32'd2);
    chk("rf_tap",  32'(tap),  32'h52);
    chk("rf_q",    32'(q),    32'h30);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
    chk("fl2_fill", 32'(fill), 32'd0);

    // Fill up, then reset + flush + en together
    push(1'b1, 8'h61);
    push(1'b1, 8'h62);
    push(1'b1, 8'h63);
    push(1'b1, 8'h64);
    chk("full_primed", 32'(primed), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    chk("rst2_q",      32'(q),       32'hA5);
    chk("rst2_tap",    32'(tap),     32'hA5);
    chk("rst2_qv",     32'(q_valid), 32'd0);
    chk("rst2_fill",   32'(fill),    32'd0);
    chk("rst2_primed", 32'(primed),  32'd0);

    // Short post-reset stream with a bubble
    push(1'b1, 8'h81);
    push(1'b0, 8'h82);
    push(1'b1, 8'h83);
    chk("post_fill", 32'(fill), 32'd2);
    push(1'b1, 8'h84);
    chk("post_q", 32'(q), 32'h81);

    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
